// File: rtl/minmax_pkg.sv
// Shared types and default sizing for the signed per-packet min/max tracker.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } minmax_state_t;

    localparam int unsigned DefaultN      = 32;
    localparam int unsigned DefaultMaxLen = 256;

endpackage

// File: rtl/comparator_lt.sv
// Signed two's-complement less-than: lt_o = (a_i < b_i).
module comparator_lt #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         lt_o
);

    assign lt_o = $signed(a_i) < $signed(b_i);

endmodule

// File: rtl/signed_minmax_tracker.sv
// Streaming per-packet signed min/max/count tracker; one summary record per packet,
// force-closed (trunc) when MAX_LEN samples arrive without in_last.
module signed_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned N       = DefaultN,
    parameter int unsigned MAX_LEN = DefaultMaxLen
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [N-1:0]                   in_data_i,
    input  logic                           in_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [N-1:0]                   out_min_o,
    output logic [N-1:0]                   out_max_o,
    output logic [$clog2(MAX_LEN+1)-1:0]   out_count_o,
    output logic                           out_trunc_o
);

    localparam int unsigned    CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]  MaxCount = CW'(MAX_LEN);
    localparam logic [CW-1:0]  OneCount = CW'(1);

    minmax_state_t state_q, state_d;
    logic [N-1:0]  min_q, min_d;
    logic [N-1:0]  max_q, max_d;
    logic [CW-1:0] count_q, count_d;
    logic          trunc_q, trunc_d;

    logic          in_xfer;
    logic          new_lt_min;
    logic          max_lt_new;

    comparator_lt #(.N(N)) lt_min (
        .a_i  (in_data_i),
        .b_i  (min_q),
        .lt_o (new_lt_min)
    );

    comparator_lt #(.N(N)) lt_max (
        .a_i  (max_q),
        .b_i  (in_data_i),
        .lt_o (max_lt_new)
    );

    assign in_ready_o  = (state_q != HOLD);
    assign out_valid_o = (state_q == HOLD);
    assign in_xfer     = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        trunc_d = trunc_q;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    min_d   = in_data_i;
                    max_d   = in_data_i;
                    count_d = OneCount;
                    trunc_d = 1'b0;
                    if (in_last_i) begin
                        state_d = HOLD;
                    end else if (OneCount == MaxCount) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    if (new_lt_min) min_d = in_data_i;
                    if (max_lt_new) max_d = in_data_i;
                    count_d = count_q + OneCount;
                    // in_last wins over the length cap on the final allowed sample.
                    if (in_last_i) begin
                        state_d = HOLD;
                        trunc_d = 1'b0;
                    end else if (count_d == MaxCount) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    assign out_min_o   = min_q;
    assign out_max_o   = max_q;
    assign out_count_o = count_q;
    assign out_trunc_o = trunc_q;

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench for signed_minmax_tracker with a short MAX_LEN to reach truncation.
module tb_signed_minmax_tracker;

    localparam int unsigned N      = 32;
    localparam int unsigned MaxLen = 4;
    localparam int unsigned CW     = $clog2(MaxLen + 1);

    typedef struct packed {
        logic [N-1:0]  mn;
        logic [N-1:0]  mx;
        logic [CW-1:0] cnt;
        logic          trunc;
    } rec_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic [N-1:0]  in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_count;
    logic          out_trunc;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_popped = 0;

    rec_t sb_q[$];

    logic         pk_open = 1'b0;
    logic [N-1:0] pk_min  = '0;
    logic [N-1:0] pk_max  = '0;
    int           pk_cnt  = 0;

    signed_minmax_tracker #(
        .N       (N),
        .MAX_LEN (MaxLen)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_min_o   (out_min),
        .out_max_o   (out_max),
        .out_count_o (out_count),
        .out_trunc_o (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_record", 64'(1), 64'(0));
            end else begin
                rec_t exp_r;
                exp_r = sb_q.pop_front();
                n_popped++;
                check_eq("rec_min",   64'(out_min),   64'(exp_r.mn));
                check_eq("rec_max",   64'(out_max),   64'(exp_r.mx));
                check_eq("rec_count", 64'(out_count), 64'(exp_r.cnt));
                check_eq("rec_trunc", 64'(out_trunc), 64'(exp_r.trunc));
            end
        end
    end

    // Drive one sample, wait (bounded) for acceptance, then update the packet model.
    task automatic send(input logic [N-1:0] d, input logic last);
        int   waited = 0;
        logic closed = 1'b0;
        logic trunc  = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!pk_open) begin
            pk_open = 1'b1;
            pk_min  = d;
            pk_max  = d;
            pk_cnt  = 1;
        end else begin
            if ($signed(d) < $signed(pk_min)) pk_min = d;
            if ($signed(d) > $signed(pk_max)) pk_max = d;
            pk_cnt++;
        end
        if (last) begin
            closed = 1'b1;
        end else if (pk_cnt == int'(MaxLen)) begin
            closed = 1'b1;
            trunc  = 1'b1;
        end
        if (closed) begin
            sb_q.push_back('{mn: pk_min, mx: pk_max, cnt: CW'(pk_cnt), trunc: trunc});
            n_pushed++;
            pk_open = 1'b0;
            check_eq("latency_valid", 64'(out_valid), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready",  64'(in_ready),  64'(1));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_min",   64'(out_min),   64'(0));
        check_eq("rst_out_max",   64'(out_max),   64'(0));
        check_eq("rst_out_count", 64'(out_count), 64'(0));
        check_eq("rst_out_trunc", 64'(out_trunc), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Mixed-sign packet closed by in_last on sample MAX_LEN.
        send(32'd5, 1'b0);
        send(-32'sd3, 1'b0);
        send(32'd7, 1'b0);
        send(32'd0, 1'b1);

        // Signed extremes.
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b1);

        // Single-sample packet.
        send(-32'sd42, 1'b1);

        // Truncation at MAX_LEN, then sample 5 opens a fresh packet.
        send(32'd3, 1'b0);
        send(-32'sd8, 1'b0);
        send(32'd12, 1'b0);
        send(32'd1, 1'b0);
        send(32'd5, 1'b0);
        check_eq("new_pkt_no_record", 64'(out_valid), 64'(0));
        send(32'd6, 1'b1);

        // Backpressure: record held, upstream stalled, outputs stable.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'd9, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready",  64'(in_ready),  64'(0));
            check_eq("bp_out_valid", 64'(out_valid), 64'(1));
            check_eq("bp_out_min",   64'(out_min),   64'(9));
            check_eq("bp_out_max",   64'(out_max),   64'(9));
            check_eq("bp_out_count", 64'(out_count), 64'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'd1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("bp_records_drained", 64'(n_popped), 64'(n_pushed));

        // Reset mid-packet discards the partial packet.
        @(posedge clk);
        #1;
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        rst_n   = 1'b0;
        pk_open = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_in_ready",  64'(in_ready),  64'(1));
        check_eq("midrst_out_count", 64'(out_count), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(-32'sd1, 1'b1);

        repeat (5) @(negedge clk);
        check_eq("sb_empty",       64'(sb_q.size()), 64'(0));
        check_eq("records_popped", 64'(n_popped),    64'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
